// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and BCD digit constants.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam int unsigned DIG_W   = 4;
   localparam logic [3:0]  DIG_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_en.sv
// One mod-10 BCD digit with enable, synchronous clear and carry out.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : synchronous clear, wins over en
//   en      : advance the digit this cycle
//   q       : current digit value, always 0..9
//   carry_c : combinational carry, en and q at 9 (enables the next digit)
module bcd_digit_en
   import stopwatch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [DIG_W-1:0] q,
   output logic             carry_c
);

   assign carry_c = en && (q == DIG_MAX);

   // Digit register: wraps 9 -> 0 when enabled
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en) begin
         if (q == DIG_MAX) begin
            q <= '0;
         end else begin
            q <= q + DIG_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, run/pause FSM, cascaded BCD counter and
// lap (display freeze) snapshot.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   start_stop : pulse, toggles run/pause (IDLE starts running)
//   clear      : pulse, zeroes everything and returns to IDLE
//   lap        : pulse, toggles display freeze
//   cnt        : displayed BCD digits, digit 0 in [3:0]
//   running    : high in RUN
//   lap_hold   : high while display is frozen
//   overflow   : sticky full-scale wrap flag
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned NDIG     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_stop,
   input  logic                  clear,
   input  logic                  lap,
   output logic [DIG_W*NDIG-1:0] cnt,
   output logic                  running,
   output logic                  lap_hold,
   output logic                  overflow
);

   localparam int unsigned PW  = $clog2(TICK_DIV);
   localparam int unsigned CW  = DIG_W * NDIG;

   sw_state_t         state;
   logic [PW-1:0]     pre;
   logic [CW-1:0]     live;
   logic [CW-1:0]     snap;
   logic [NDIG-1:0]   en;
   logic [NDIG-1:0]   carry;
   logic              tick;

   assign tick = (state == ST_RUN) && (pre == PW'(TICK_DIV - 1));

   // Digit chain: digit k advances when tick is high and all lower digits are 9
   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      if (k == 0) begin : g_lsd
         assign en[k] = tick;
      end else begin : g_upper
         assign en[k] = carry[k-1];
      end

      bcd_digit_en u_dig (
         .clk     (clk),
         .rst     (rst),
         .clr     (clear),
         .en      (en[k]),
         .q       (live[k*DIG_W +: DIG_W]),
         .carry_c (carry[k])
      );
   end

   assign cnt = lap_hold ? snap : live;

   // FSM, prescaler, lap snapshot and overflow; clear > start_stop > lap
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         running  <= 1'b0;
         pre      <= '0;
         lap_hold <= 1'b0;
         snap     <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         state    <= ST_IDLE;
         running  <= 1'b0;
         pre      <= '0;
         lap_hold <= 1'b0;
         overflow <= 1'b0;
      end else begin
         // Prescaler holds outside RUN so a resume continues the partial tick
         if (state == ST_RUN) begin
            pre <= tick ? '0 : pre + PW'(1);
         end

         if (carry[NDIG-1]) begin
            overflow <= 1'b1;
         end

         if (start_stop) begin
            case (state)
               ST_IDLE: begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
               ST_RUN: begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end
               ST_PAUSE: begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end
            endcase
         end else if (lap) begin
            if (lap_hold && (state != ST_IDLE)) begin
               lap_hold <= 1'b0;
            end else if (!lap_hold && (state == ST_RUN)) begin
               snap     <= live;
               lap_hold <= 1'b1;
            end
         end
      end
   end

endmodule
